// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// adc_scan_sequencer: multiplexed ADC scan with conversion pacing, oversampling,
// per-channel masking and power-channel diversion.   Revision: 1.0
// ============================================================================
module adc_scan_sequencer #(
  parameter int DATA_W      = 12,
  parameter int MUX_COUNT   = 3,
  parameter int MUX_BITS    = 3,
  parameter int CHANNELS    = 24,
  parameter int SETTLE_CYC  = 16,
  parameter int AVG_LOG2    = 0,
  parameter int INVERT      = 1,
  parameter int POWER_CH    = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  output logic [MUX_BITS-1:0]  mux_addr,
  output logic [MUX_COUNT-1:0] mux_en,
  output logic                 spi_req,
  input  logic [DATA_W-1:0]    spi_data,
  input  logic                 spi_valid,
  input  logic [CHANNELS-1:0]  ch_mask,
  output logic [DATA_W-1:0]    fifo_data,
  output logic                 fifo_wr,
  input  logic                 fifo_full,
  output logic [DATA_W-1:0]    power,
  output logic                 power_chg,
  output logic                 cycle_done,
  output logic                 overflow,
  output logic                 timeout_err
);

  localparam int CH_W    = MUX_BITS + ((MUX_COUNT > 1) ? $clog2(MUX_COUNT) : 1);
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NCONV_W = AVG_LOG2 + 1;

  localparam logic [NCONV_W-1:0] LAST_CONV   = NCONV_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0]    PWR_CH      = CH_W'(POWER_CH);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    ST_SETTLE    = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_CONVERT   = 3'd2,
    ST_EMIT      = 3'd3,
    ST_ADVANCE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [NCONV_W-1:0]  nconv;
  logic [DATA_W-1:0]   conv_raw, sample, result;
  logic                mask_sel, timed_out, conv_done, last_conv;

  // A timed-out conversion contributes a raw zero, which still goes through inversion.
  assign timed_out = (state == ST_CONVERT) && !spi_valid && (cnt == TIMEOUT_LIM);
  assign conv_done = (state == ST_CONVERT) && (spi_valid || timed_out);
  assign last_conv = (nconv == LAST_CONV);
  assign conv_raw  = spi_valid ? spi_data : '0;
  assign sample    = (INVERT != 0) ? ~conv_raw : conv_raw;
  assign acc_nxt   = acc + ACC_W'(sample);
  assign result    = DATA_W'(acc_nxt >> AVG_LOG2);
  assign mask_sel  = |(ch_mask & (CHANNELS'(1) << ch));
  assign ch_nxt    = (ch == LAST_CH) ? '0 : ch + CH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SETTLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SETTLE:    if (cnt == '0) state_nxt = ST_WAIT_TICK;
      ST_WAIT_TICK: if (sample_tick) state_nxt = ST_CONVERT;
      ST_CONVERT:   if (conv_done) state_nxt = last_conv ? ST_EMIT : ST_WAIT_TICK;
      ST_EMIT:      state_nxt = ST_ADVANCE;
      ST_ADVANCE:   state_nxt = ST_SETTLE;
      default:      state_nxt = ST_SETTLE;
    endcase
  end

  // Routing decisions are registered on the accepting cycle so the strobes are
  // visible during EMIT, one cycle after the final spi_valid or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= SETTLE_LOAD;
      ch          <= '0;
      acc         <= '0;
      nconv       <= '0;
      mux_addr    <= '0;
      mux_en      <= MUX_COUNT'(1);
      spi_req     <= 1'b0;
      fifo_data   <= '0;
      fifo_wr     <= 1'b0;
      power       <= '0;
      power_chg   <= 1'b0;
      cycle_done  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      spi_req    <= 1'b0;
      fifo_wr    <= 1'b0;
      power_chg  <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        ST_WAIT_TICK: begin
          if (sample_tick) begin
            spi_req <= 1'b1;
            cnt     <= '0;
          end
        end
        ST_CONVERT: begin
          if (conv_done) begin
            acc   <= acc_nxt;
            nconv <= nconv + NCONV_W'(1);
            if (timed_out) timeout_err <= 1'b1;
            if (last_conv) begin
              if (ch == PWR_CH) begin
                power     <= result;
                power_chg <= (result != power);
              end else if (mask_sel) begin
                if (fifo_full) begin
                  overflow <= 1'b1;
                end else begin
                  fifo_data <= result;
                  fifo_wr   <= 1'b1;
                end
              end
              cycle_done <= (ch == LAST_CH);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ADVANCE: begin
          ch       <= ch_nxt;
          acc      <= '0;
          nconv    <= '0;
          mux_addr <= ch_nxt[MUX_BITS-1:0];
          mux_en   <= MUX_COUNT'(1) << ch_nxt[CH_W-1:MUX_BITS];
          cnt      <= SETTLE_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// Directed bench: a default-shaped instance (short timeout) and an oversampling,
// non-inverting instance, both checked against hand-computed values.
module tb_adc_scan_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        tick_a, valid_a, full_a;
  logic [11:0] data_a;
  logic [23:0] mask_a;
  logic [2:0]  mux_addr_a, mux_en_a;
  logic        req_a, wr_a, pchg_a, cdone_a, ovf_a, tmo_a;
  logic [11:0] fdata_a, power_a;

  logic        tick_b, valid_b, full_b;
  logic [11:0] data_b;
  logic [23:0] mask_b;
  logic [2:0]  mux_addr_b, mux_en_b;
  logic        req_b, wr_b, pchg_b, cdone_b, ovf_b, tmo_b;
  logic [11:0] fdata_b, power_b;

  adc_scan_sequencer #(.TIMEOUT_CYC(20)) u_dut_a (
    .clk(clk), .reset(reset), .sample_tick(tick_a),
    .mux_addr(mux_addr_a), .mux_en(mux_en_a), .spi_req(req_a),
    .spi_data(data_a), .spi_valid(valid_a), .ch_mask(mask_a),
    .fifo_data(fdata_a), .fifo_wr(wr_a), .fifo_full(full_a),
    .power(power_a), .power_chg(pchg_a), .cycle_done(cdone_a),
    .overflow(ovf_a), .timeout_err(tmo_a)
  );

  adc_scan_sequencer #(.AVG_LOG2(2), .INVERT(0)) u_dut_b (
    .clk(clk), .reset(reset), .sample_tick(tick_b),
    .mux_addr(mux_addr_b), .mux_en(mux_en_b), .spi_req(req_b),
    .spi_data(data_b), .spi_valid(valid_b), .ch_mask(mask_b),
    .fifo_data(fdata_b), .fifo_wr(wr_b), .fifo_full(full_b),
    .power(power_b), .power_chg(pchg_b), .cycle_done(cdone_b),
    .overflow(ovf_b), .timeout_err(tmo_b)
  );

  int checks = 0;
  int failures = 0;
  int n_wr_a = 0, n_pchg_a = 0, n_cdone_a = 0, n_req_b = 0;

  always @(negedge clk) begin
    if (wr_a)    n_wr_a++;
    if (pchg_a)  n_pchg_a++;
    if (cdone_a) n_cdone_a++;
    if (req_b)   n_req_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Hold the tick until a request appears; returns the cycles waited.
  task automatic await_req(input bit b, output int waited);
    logic req;
    waited = 0;
    if (b) tick_b = 1'b1; else tick_a = 1'b1;
    do begin
      step();
      waited++;
      req = b ? req_b : req_a;
    end while (!req && waited < 200);
    tick_a = 1'b0;
    tick_b = 1'b0;
    check("req_seen", req, 1);
  endtask

  task automatic respond(input bit b, input logic [11:0] d);
    if (b) begin data_b = d; valid_b = 1'b1; end
    else   begin data_a = d; valid_a = 1'b1; end
    step();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic do_chan_a(input int c, input bit chk_wait, input bit first_scan);
    int w;
    await_req(1'b0, w);
    if (chk_wait) check("settle_wait", w, 19);
    check("mux_en", mux_en_a, 1 << (c >> 3));
    check("mux_addr", mux_addr_a, c & 7);
    respond(1'b0, 12'(c));
    check("mux_en_hold", mux_en_a, 1 << (c >> 3));
    check("cycle_done", cdone_a, (c == 23));
    if (c == 1) begin
      check("pwr_no_wr", wr_a, 0);
      check("power", power_a, 4094);
      check("power_chg", pchg_a, first_scan);
    end else if (mask_a[c] && !full_a) begin
      check("fifo_wr", wr_a, 1);
      check("fifo_data", fdata_a, 4095 - c);
    end else begin
      check("no_wr", wr_a, 0);
    end
  endtask

  task automatic check_reset_a();
    check("rst_mux_addr", mux_addr_a, 0);
    check("rst_mux_en", mux_en_a, 1);
    check("rst_req", req_a, 0);
    check("rst_fifo_data", fdata_a, 0);
    check("rst_fifo_wr", wr_a, 0);
    check("rst_power", power_a, 0);
    check("rst_pchg", pchg_a, 0);
    check("rst_cdone", cdone_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_timeout", tmo_a, 0);
  endtask

  initial begin
    int base_wr, base_cd, base_pc, base_req, w;
    reset = 1'b1;
    tick_a = 0; valid_a = 0; full_a = 0; data_a = '0; mask_a = '1;
    tick_b = 0; valid_b = 0; full_b = 0; data_b = '0; mask_b = '1;
    repeat (3) step();
    check_reset_a();
    check("rst_mux_en_b", mux_en_b, 1);
    reset = 1'b0;

    // Scan 1: every channel written except the power channel
    base_wr = n_wr_a; base_cd = n_cdone_a; base_pc = n_pchg_a;
    for (int c = 0; c < 24; c++) do_chan_a(c, c != 0, 1'b1);
    check("scan1_writes", n_wr_a - base_wr, 23);
    check("scan1_cdone", n_cdone_a - base_cd, 1);
    check("scan1_pchg", n_pchg_a - base_pc, 1);

    // Scan 2: wrap, full FIFO on channel 3, masked channel 5, stray valid in SETTLE
    base_wr = n_wr_a; base_cd = n_cdone_a; base_pc = n_pchg_a;
    for (int c = 0; c < 24; c++) begin
      if (c == 3) full_a = 1'b1;
      if (c == 5) begin
        mask_a[5] = 1'b0;
        repeat (2) step();
        data_a = 12'd99; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check("stray_no_wr", wr_a, 0);
        step();
        check("stray_no_wr2", wr_a, 0);
        check("stray_no_cdone", cdone_a, 0);
        check("stray_no_pchg", pchg_a, 0);
      end
      do_chan_a(c, (c != 5), 1'b0);
      if (c == 3) begin
        full_a = 1'b0;
        check("overflow_set", ovf_a, 1);
      end
      if (c == 4) check("overflow_sticky", ovf_a, 1);
      if (c == 5) begin
        check("overflow_unchanged", ovf_a, 1);
        mask_a[5] = 1'b1;
      end
    end
    check("scan2_writes", n_wr_a - base_wr, 21);
    check("scan2_cdone", n_cdone_a - base_cd, 1);
    check("scan2_pchg", n_pchg_a - base_pc, 0);
    check("scan2_power", power_a, 4094);

    // Timeout on channel 0: error 21 cycles after the request, inverted zero written
    await_req(1'b0, w);
    repeat (20) step();
    check("tmo_early", tmo_a, 0);
    check("tmo_early_wr", wr_a, 0);
    step();
    check("tmo_set", tmo_a, 1);
    check("tmo_wr", wr_a, 1);
    check("tmo_data", fdata_a, 4095);

    // Reset in the middle of channel 1's conversion
    await_req(1'b0, w);
    repeat (3) step();
    reset = 1'b1;
    step();
    check_reset_a();
    reset = 1'b0;
    base_wr = n_wr_a;
    data_a = 12'd7; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    repeat (4) step();
    check("late_valid_no_wr", n_wr_a - base_wr, 0);
    do_chan_a(0, 1'b0, 1'b1);

    // Oversampling instance: (10+11+12+14)>>2 = 11, four requests, one settle
    repeat (20) step();
    base_req = n_req_b;
    await_req(1'b1, w);
    respond(1'b1, 12'd10);
    check("b_mid_no_wr", wr_b, 0);
    await_req(1'b1, w);
    check("b_no_resettle1", w, 1);
    respond(1'b1, 12'd11);
    await_req(1'b1, w);
    check("b_no_resettle2", w, 1);
    respond(1'b1, 12'd12);
    await_req(1'b1, w);
    check("b_no_resettle3", w, 1);
    respond(1'b1, 12'd14);
    check("b_fifo_wr", wr_b, 1);
    check("b_fifo_data", fdata_b, 11);
    check("b_req_count", n_req_b - base_req, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Parametrised successor to the analog front-end sequencing (mux switcher plus sample distributor) used ahead of the telemetry frame filler. It walks CHANNELS analog inputs across MUX_COUNT multiplexers and paces conversions from a sample tick. Each conversion is requested from the SPI ADC receiver. Samples are optionally inverted and oversampled, masked channels are dropped, and results go to the analog FIFO. One channel is diverted to a power register with a change strobe. It adds per-channel masking, oversampling, conversion timeout and FIFO overflow detection.

Parameters:
DATA_W, 12, ADC sample width
MUX_COUNT, 3, number of analog multiplexers
MUX_BITS, 3, address bits per mux; CHANNELS <= MUX_COUNT*2^MUX_BITS
CHANNELS, 24, channels scanned per cycle
SETTLE_CYC, 16, clk cycles of settling after every mux change (>=1)
AVG_LOG2, 0, oversampling: 2^AVG_LOG2 conversions averaged per channel
INVERT, 1, 1: sample = (2^DATA_W-1) - spi_data
POWER_CH, 1, channel index diverted to power register
TIMEOUT_CYC, 1023, max clk cycles waiting for spi_valid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sample_tick  in  1  conversion pacing pulse
mux_addr  out  MUX_BITS  address shared by all muxes
mux_en  out  MUX_COUNT  one-hot enable of active mux
spi_req  out  1  one-cycle conversion request to SPI receiver
spi_data  in  DATA_W  conversion result
spi_valid  in  1  one-cycle result strobe
ch_mask  in  CHANNELS  1 = forward channel to FIFO
fifo_data  out  DATA_W  sample to analog FIFO
fifo_wr  out  1  one-cycle write strobe
fifo_full  in  1  FIFO full
power  out  DATA_W  latest power-channel sample
power_chg  out  1  one-cycle pulse when power value changed
cycle_done  out  1  one-cycle pulse at end of each full scan
overflow  out  1  sticky: sample dropped on fifo_full
timeout_err  out  1  sticky: conversion timed out

Behaviour:
- Reset (synchronous, active-high) overrides everything and is honoured in any state, including mid-conversion.
- Reset values: channel index 0, mux_addr 0, mux_en = 1 (mux 0), all strobes 0, fifo_data 0, power 0, overflow 0, timeout_err 0.
- After reset the FSM enters SETTLE.
- Channel c decodes to mux_en bit (c >> MUX_BITS) and mux_addr = c[MUX_BITS-1:0]. Both are registered and change only in ADVANCE.
- FSM states and transitions:
  - SETTLE: load the counter with SETTLE_CYC and count down; at zero go to WAIT_TICK.
  - WAIT_TICK: on sample_tick, pulse spi_req for exactly one cycle and go to CONVERT. A tick arriving in any other state is ignored, not queued.
  - CONVERT: on spi_valid, add the (optionally inverted) sample to the accumulator (width DATA_W+AVG_LOG2) and increment the conversion count. If the count is below 2^AVG_LOG2, return to WAIT_TICK with no re-settle; otherwise go to EMIT. spi_valid in any other state is ignored.
  - CONVERT timeout: if no spi_valid arrives within TIMEOUT_CYC cycles of spi_req, set timeout_err, accumulate 0 and proceed as if valid arrived.
  - EMIT (1 cycle): result = acc >> AVG_LOG2 (floor).
    - If c == POWER_CH: power <= result, and power_chg pulses if result != previous power. The FIFO is never written for the power channel, regardless of ch_mask.
    - Else if ch_mask[c] and !fifo_full: fifo_data <= result and fifo_wr pulses.
    - Else if ch_mask[c] and fifo_full: drop the sample, set overflow, no fifo_wr.
    - Else (unmasked): drop silently.
    - If c == CHANNELS-1: cycle_done pulses in this cycle.
  - ADVANCE (1 cycle): c <= (c == CHANNELS-1) ? 0 : c+1; clear accumulator and count; update mux outputs; go to SETTLE.
- Latency: the EMIT strobes (fifo_wr, power_chg, cycle_done) appear exactly 1 cycle after the accepting spi_valid cycle, or after the timeout cycle.
- The accumulator cannot overflow: its width is DATA_W+AVG_LOG2 bits.
- overflow and timeout_err clear only on reset.
- When the power channel's result equals the previous power value, power_chg stays 0.
- A spi_valid arriving after reset is ignored until a new spi_req has been issued.

Test Plan:
1. Defaults, ch_mask all 1, INVERT=1, spi_data = channel number, one tick per WAIT_TICK -> 23 fifo_wr per scan carrying values 4095-c (channel 1 absent), power = 4094, power_chg once on the first scan only, cycle_done once per 24 channels, channels wrap to 0.
2. Mux sequencing: observe across channels 7→8 and 23→0 -> mux_en 001→010 with mux_addr 7→0; mux_en 100→001; SETTLE_CYC cycles elapse before the next spi_req can issue.
3. AVG_LOG2=2, INVERT=0, samples 10, 11, 12, 14 on channel 0 -> one fifo_wr with data 11, exactly 4 spi_req pulses, only one settle period.
4. fifo_full held high during channel 3 EMIT -> no fifo_wr, overflow=1 and stays 1; channel 4 writes normally after fifo_full drops.
5. ch_mask[5]=0 -> no write for channel 5, overflow unchanged; spi_valid injected during SETTLE -> ignored, no strobes.
6. Withhold spi_valid with TIMEOUT_CYC=20 -> timeout_err=1 21 cycles after spi_req, fifo_data 4095 (inverted 0). Assert reset mid-CONVERT -> all outputs at reset values, channel 0, a late spi_valid produces no fifo_wr.
